// File: rtl/rr_arbiter8_pkg.sv
// Shared constants and state encoding for the 8-way round-robin arbiter.
// Imported by the winner picker and the arbiter top.
package rr_arbiter8_pkg;

  localparam int unsigned N_REQ           = 8;
  localparam int unsigned ID_W            = 3;
  localparam int unsigned DEFAULT_TIMEOUT = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Active-low one-hot grant vector for a given owner index.
  function automatic logic [N_REQ-1:0] gnt_decode(input logic [ID_W-1:0] id);
    logic [N_REQ-1:0] v;
    v     = '1;
    v[id] = 1'b0;
    return v;
  endfunction

endpackage

// File: rtl/rr_arbiter8_pick.sv
// Combinational round-robin winner search: the first requesting index at or
// after ptr, scanning upward and wrapping from 7 back to 0.
module rr_pick8
  import rr_arbiter8_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [ID_W-1:0]  id,
  output logic             any
);

  logic [ID_W-1:0] idx;

  always_comb begin
    id  = '0;
    any = 1'b0;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = ptr + ID_W'(i);
      if (!any && req[idx]) begin
        id  = idx;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter8.sv
// 8-requester round-robin arbiter with a per-grant hold timeout and a
// one-cycle dead gap between owners. All outputs come straight from flops.
module rr_arbiter8
  import rr_arbiter8_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] iReq,
  input  logic             iDone,
  output logic [N_REQ-1:0] oGnt,
  output logic [ID_W-1:0]  oGntId,
  output logic             oBusy,
  output logic             oTimeout
);

  localparam logic [7:0] HOLD_LAST = 8'(TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [ID_W-1:0]  ptr, ptr_nxt;
  logic [7:0]       hold_cnt, hold_nxt;
  logic [N_REQ-1:0] gnt, gnt_nxt;
  logic [ID_W-1:0]  gnt_id, gnt_id_nxt;
  logic             busy, busy_nxt;
  logic             timeout, timeout_nxt;

  logic [ID_W-1:0]  pick_id;
  logic             pick_any;
  logic             owner_req;
  logic             hold_hit;
  logic             release_hit;

  rr_pick8 u_pick (
    .req (iReq),
    .ptr (ptr),
    .id  (pick_id),
    .any (pick_any)
  );

  assign owner_req   = iReq[gnt_id];
  assign hold_hit    = (hold_cnt == HOLD_LAST);
  assign release_hit = iDone || !owner_req;

  // Next-state and next-output logic; a grant ended by iDone never reports
  // a timeout even if the hold limit was reached on the same edge.
  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    hold_nxt    = hold_cnt;
    gnt_nxt     = gnt;
    gnt_id_nxt  = gnt_id;
    busy_nxt    = busy;
    timeout_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (pick_any) begin
          state_nxt  = GRANT;
          ptr_nxt    = pick_id + ID_W'(1);
          hold_nxt   = '0;
          gnt_nxt    = gnt_decode(pick_id);
          gnt_id_nxt = pick_id;
          busy_nxt   = 1'b1;
        end
      end
      GRANT: begin
        hold_nxt = hold_cnt + 8'd1;
        if (release_hit || hold_hit) begin
          state_nxt   = GAP;
          gnt_nxt     = '1;
          busy_nxt    = 1'b0;
          timeout_nxt = hold_hit && !iDone;
        end
      end
      GAP: begin
        state_nxt = IDLE;
        gnt_nxt   = '1;
        busy_nxt  = 1'b0;
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '1;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // Reset revokes any grant asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      gnt      <= '1;
      gnt_id   <= '0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      hold_cnt <= hold_nxt;
      gnt      <= gnt_nxt;
      gnt_id   <= gnt_id_nxt;
      busy     <= busy_nxt;
      timeout  <= timeout_nxt;
    end
  end

  assign oGnt     = gnt;
  assign oGntId   = gnt_id;
  assign oBusy    = busy;
  assign oTimeout = timeout;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Scoreboard bench for rr_arbiter8: stimulus queues expected grants, a
// monitor checks each grant start and end as the DUT presents it.
module tb_rr_arbiter8;

  logic       clk;
  logic       rst_n;
  logic [7:0] iReq;
  logic       iDone;
  logic [7:0] oGnt;
  logic [2:0] oGntId;
  logic       oBusy;
  logic       oTimeout;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [2:0] id;
    logic       to;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  logic have_cur = 1'b0;
  logic prev_busy = 1'b0;
  logic [7:0] exp_gnt;

  rr_arbiter8 #(.TIMEOUT(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .iReq     (iReq),
    .iDone    (iDone),
    .oGnt     (oGnt),
    .oGntId   (oGntId),
    .oBusy    (oBusy),
    .oTimeout (oTimeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: a grant start pops the next expected item, a grant end checks
  // the timeout flag against it.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_busy = 1'b0;
      have_cur  = 1'b0;
    end else begin
      if (oBusy && !prev_busy) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_grant: id=%0d gnt=%h, none expected", oGntId, oGnt);
        end else begin
          cur     = exp_q.pop_front();
          exp_gnt = ~(8'h01 << cur.id);
          have_cur = 1'b1;
          if (oGntId !== cur.id || oGnt !== exp_gnt) begin
            errors++;
            $display("[TB] FAIL grant_start: id=%0d gnt=%h, required id=%0d gnt=%h",
                     oGntId, oGnt, cur.id, exp_gnt);
          end
        end
      end else if (!oBusy && prev_busy && have_cur) begin
        checks++;
        have_cur = 1'b0;
        if (oTimeout !== cur.to || oGnt !== 8'hFF) begin
          errors++;
          $display("[TB] FAIL grant_end: id=%0d timeout=%b gnt=%h, required timeout=%b gnt=ff",
                   cur.id, oTimeout, oGnt, cur.to);
        end
      end
      prev_busy = oBusy;
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic post_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    post_edge();
    rst_n = 1'b0;
    iReq  = 8'h00;
    iDone = 1'b0;
    post_edge();
    post_edge();
    rst_n = 1'b1;
  endtask

  task automatic wait_busy(input string name);
    int n = 0;
    while (oBusy !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: no grant within 20 cycles", name);
    end
  endtask

  task automatic pulse_done();
    iDone = 1'b1;
    post_edge();
    iDone = 1'b0;
  endtask

  // Grant once per expected id, releasing via iDone after two grant cycles.
  task automatic applyStimulus(input logic [7:0] req, input logic [2:0] ids[], input string name);
    iReq = req;
    for (int i = 0; i < ids.size(); i++) begin
      exp_q.push_back('{id: ids[i], to: 1'b0});
      wait_busy(name);
      post_edge();
      pulse_done();
      if (i == ids.size() - 1) iReq = 8'h00;
    end
  endtask

  initial begin
    int cnt;
    logic [2:0] ids_a[];
    logic [2:0] ids_b[];
    logic [2:0] ids_c[];
    rst_n = 1'b0;
    iReq  = 8'h00;
    iDone = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_gnt",     oGnt,           8'hFF);
    checkOutput("reset_id",      {5'd0, oGntId}, 8'h00);
    checkOutput("reset_busy",    {7'd0, oBusy},  8'h00);
    checkOutput("reset_timeout", {7'd0, oTimeout}, 8'h00);

    post_edge();
    rst_n = 1'b1;
    ids_a = new[2];
    ids_a[0] = 3'd0;
    ids_a[1] = 3'd0;
    applyStimulus(8'h01, ids_a, "single_req");

    do_reset();
    ids_b = new[9];
    for (int i = 0; i < 9; i++) ids_b[i] = 3'(i % 8);
    applyStimulus(8'hFF, ids_b, "all_req_rotation");

    do_reset();
    ids_c = new[3];
    ids_c[0] = 3'd0;
    ids_c[1] = 3'd7;
    ids_c[2] = 3'd0;
    applyStimulus(8'h81, ids_c, "wrap_7_0");

    // Hold limit reached with no release.
    do_reset();
    exp_q.push_back('{id: 3'd2, to: 1'b1});
    iReq = 8'h04;
    wait_busy("timeout_grant");
    cnt = 0;
    while (oGnt === 8'hFB && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
    checkOutput("timeout_len", 8'(cnt), 8'd4);
    exp_q.push_back('{id: 3'd2, to: 1'b0});
    @(negedge clk);
    checkOutput("timeout_one_cycle", {7'd0, oTimeout}, 8'h00);
    wait_busy("timeout_regrant");
    #2;
    iReq = 8'h00;

    // iDone on the very edge the hold limit is reached.
    do_reset();
    exp_q.push_back('{id: 3'd3, to: 1'b0});
    iReq = 8'h08;
    wait_busy("done_vs_timeout");
    repeat (3) post_edge();
    pulse_done();
    iReq = 8'h00;
    repeat (3) post_edge();

    // iDone with nothing granted must not start anything.
    pulse_done();
    @(negedge clk);
    checkOutput("idle_done_ignored", {7'd0, oBusy}, 8'h00);

    // Reset mid-grant revokes asynchronously.
    exp_q.push_back('{id: 3'd1, to: 1'b0});
    iReq = 8'h02;
    wait_busy("pre_reset_grant");
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("async_revoke_gnt",  oGnt,          8'hFF);
    checkOutput("async_revoke_busy", {7'd0, oBusy}, 8'h00);
    iReq = 8'h10;
    post_edge();
    rst_n = 1'b1;
    exp_q.push_back('{id: 3'd4, to: 1'b0});
    wait_busy("post_reset_grant");
    // A non-owner request change must not disturb the grant.
    #2;
    iReq = 8'h18;
    @(negedge clk);
    checkOutput("non_owner_ignored", oGnt, 8'hEF);
    iReq = 8'h00;
    repeat (4) post_edge();

    checkOutput("queue_drained", 8'(exp_q.size()), 8'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_arbiter8.md
RR_ARBITER8 -- requirements
Module: rr_arbiter8

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, maximum grant length in cycles (range 1..255).
REQ-002 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port iReq  input  8  request per requester, active-high, level.
REQ-005 SHALL have port iDone  input  1  current owner releases the resource, active-high, one-cycle pulse.
REQ-006 SHALL have port oGnt  output  8  one-hot grant, active-low; at most one bit low.
REQ-007 SHALL have port oGntId  output  3  index of the current owner; valid only while oBusy=1.
REQ-008 SHALL have port oBusy  output  1  resource owned.
REQ-009 SHALL have port oTimeout  output  1  one-cycle pulse when a grant is revoked by timeout.

Function
REQ-010 SHALL drive all outputs from registers; no combinational path from inputs to outputs.
REQ-011 SHALL implement FSM states IDLE, GRANT, GAP.
REQ-012 IDLE: if any iReq bit is 1, SHALL select a winner and enter GRANT at the next edge; otherwise stay in IDLE.
REQ-013 Latency SHALL be one cycle: iReq sampled at edge N -> oGnt[winner]=0, oBusy=1, oGntId=winner after edge N.
REQ-014 Winner SHALL be the first requesting index at or after pointer ptr, searching upward with wrap 7->0.
REQ-015 On entering GRANT, ptr SHALL load (winner+1) mod 8.
REQ-016 GRANT SHALL exit to GAP on the first edge with iDone=1, iReq[owner]=0, or hold counter = TIMEOUT-1.
REQ-017 Hold counter SHALL be 8 bits, SHALL clear on entering GRANT, and SHALL increment once per GRANT cycle.
REQ-018 If iDone and timeout occur on the same edge, iDone SHALL take precedence and oTimeout SHALL stay 0.
REQ-019 oTimeout SHALL pulse for exactly the one cycle after the timeout-caused GRANT->GAP edge.
REQ-020 GAP SHALL last exactly one cycle with oGnt=8'hFF and oBusy=0, then go to IDLE.
REQ-021 iDone outside GRANT SHALL be ignored.
REQ-022 iReq changes of non-owners during GRANT SHALL be ignored.
REQ-023 The same requester SHALL NOT be granted twice in a row while any other requester is pending.

Reset
REQ-024 While rst_n=0: state=IDLE, ptr=0, hold counter=0.
REQ-025 While rst_n=0: oGnt=8'hFF, oGntId=0, oBusy=0, oTimeout=0.
REQ-026 Reset asserted mid-GRANT SHALL revoke the grant immediately (asynchronously).
REQ-027 After rst_n deasserts, the first arbitration SHALL occur on the first rising edge.

Structure
REQ-028 A shared package SHALL hold N_REQ=8, ID_W=3, the state encoding (IDLE=2'd0, GRANT=2'd1, GAP=2'd2), and the default TIMEOUT.
REQ-029 Winner selection SHALL be a combinational sub-module rr_pick8 (inputs: req[7:0], ptr[2:0]; outputs: id[2:0], any).
REQ-030 The active-low one-hot oGnt SHALL be derived from the winner id using 3-to-8 decoding inside rr_arbiter8.
REQ-031 State encoding value 2'd3 SHALL recover to IDLE.

Verification
REQ-032 Reset then iReq=8'h01 held: oGnt=8'hFE, oGntId=0, oBusy=1 one cycle later; iDone pulse -> one GAP cycle with oGnt=8'hFF, then regrant to 0.
REQ-033 iReq=8'hFF held, iDone after every 2 grant cycles: grant ids SHALL be 0,1,2,…,7,0 in order.
REQ-034 iReq=8'h81 with ptr=0: grant 0, then 7, then 0.
REQ-035 TIMEOUT=4, iReq=8'h04 held, no iDone: oGnt=8'hFB for exactly 4 cycles, oTimeout=1 for one cycle, GAP, then regrant to 2.
REQ-036 iDone and timeout on the same edge -> oTimeout=0.
REQ-037 rst_n pulsed low mid-GRANT -> oGnt=8'hFF immediately; after release, iReq=8'h10 -> grant 4.
